hdc_class_trainer: RTL and testbench

HDC_CLASS_TRAINER -- requirements
Module: hdc_class_trainer

---
 rtl/hdc_pkg.sv | 31 +++
 rtl/hdc_acc_bank.sv | 61 ++++++
 rtl/hdc_class_trainer.sv | 195 +++++++++++++++++++
 tb/tb_hdc_class_trainer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// hdc_pkg: shared encodings for the HDC class trainer.
// Holds the bipolar element codes, the class label values and the
// controller state type.
package hdc_pkg;

  // Two-bit signed bipolar element codes (2'b10 is decoded as zero).
  localparam logic [1:0] ELEM_ZERO = 2'b00;
  localparam logic [1:0] ELEM_POS  = 2'b01;
  localparam logic [1:0] ELEM_NEG  = 2'b11;

  // Class labels carried on in_label.
  localparam logic LABEL_HAM  = 1'b1;
  localparam logic LABEL_SPAM = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACCUM = 2'd2,
    ST_FINAL = 2'd3
  } state_t;

  // Decode an element code into a signed step of -1, 0 or +1.
  function automatic logic signed [1:0] elem_value(input logic [1:0] elem);
    case (elem)
      ELEM_POS: elem_value = 2'sb01;
      ELEM_NEG: elem_value = 2'sb11;
      default:  elem_value = 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/hdc_acc_bank.sv
// hdc_acc_bank: DIM x ACC_W signed accumulator array for one class.
// One write index shared by the add and clear paths, plus an independent
// combinational read port for the output sweep.
// Build option: HDC_TRAIN_SAT_EN makes the add saturate at the signed
// ACC_W limits; without it the add wraps modulo 2^ACC_W.
module hdc_acc_bank
  import hdc_pkg::*;
#(
  parameter int DIM   = 10000,
  parameter int ACC_W = 16,
  parameter int IDX_W = $clog2(DIM)
) (
  input  logic                    clk,
  input  logic                    i_clr,
  input  logic                    i_add,
  input  logic [IDX_W-1:0]        i_wr_idx,
  input  logic [1:0]              i_elem,
  input  logic [IDX_W-1:0]        i_rd_idx,
  output logic signed [ACC_W-1:0] o_rd_data
);

  logic [ACC_W-1:0] r_mem [DIM];
  logic [ACC_W-1:0] w_cur;
  logic [ACC_W-1:0] w_next;
  logic signed [1:0] w_step;

  assign w_cur     = r_mem[i_wr_idx];
  assign w_step    = elem_value(i_elem);
  assign o_rd_data = r_mem[i_rd_idx];

`ifdef HDC_TRAIN_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] w_sum;

  assign w_sum = {w_cur[ACC_W-1], w_cur} + {{(ACC_W-1){w_step[1]}}, w_step};

  // Clamp to the signed range when the extra sign bit disagrees.
  always_comb begin
    // NOTE: default assignment first, so no path leaves w_next unassigned and infers a latch.
    w_next = w_sum[ACC_W-1:0];
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
      w_next = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  assign w_next = w_cur + {{(ACC_W-2){w_step[1]}}, w_step};
`endif

  // Clear wins over add so a sweep always leaves zeros behind.
  // NOTE: the array has no reset; the controller runs a clear sweep after every reset instead.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_mem[i_wr_idx] <= '0;
    end else if (i_add) begin
      r_mem[i_wr_idx] <= w_next;
    end
  end

endmodule

// File: rtl/hdc_class_trainer.sv
// hdc_class_trainer: two-class (ham/spam) hypervector trainer.
// Streams bipolar sample elements into per-class accumulators, counts
// completed samples per class and streams the binarized class vectors out.
// Build option: HDC_TRAIN_SAT_EN selects saturating accumulation
// (default build wraps modulo 2^ACC_W).
module hdc_class_trainer
  import hdc_pkg::*;
#(
  parameter  int DIM   = 10000,
  parameter  int ACC_W = 16,
  parameter  int CNT_W = 16,
  localparam int IDX_W = $clog2(DIM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_clear,
  input  logic             cmd_final,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_elem,
  input  logic             in_label,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [1:0]       out_ham,
  output logic [1:0]       out_spam,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] ham_count,
  output logic [CNT_W-1:0] spam_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_label;
  logic              r_out_valid;
  logic [IDX_W-1:0]  r_out_idx;
  logic [1:0]        r_out_ham;
  logic [1:0]        r_out_spam;
  logic              r_out_last;
  logic [CNT_W-1:0]  r_ham_count;
  logic [CNT_W-1:0]  r_spam_count;

  logic              w_in_ready;
  logic              w_in_hs;
  logic              w_cur_label;
  logic              w_ham_add;
  logic              w_spam_add;
  logic              w_clr;
  logic              w_idx_last;
  logic [IDX_W-1:0]  w_out_idx_nxt;
  logic [IDX_W-1:0]  w_rd_idx;
  logic signed [ACC_W-1:0] w_ham_rd;
  logic signed [ACC_W-1:0] w_spam_rd;

  // Map an accumulator to its sign as a bipolar element code.
  function automatic logic [1:0] binarize(input logic signed [ACC_W-1:0] acc);
    if (acc == '0) begin
      binarize = ELEM_ZERO;
    end else if (acc[ACC_W-1]) begin
      binarize = ELEM_NEG;
    end else begin
      binarize = ELEM_POS;
    end
  endfunction

  // Input is refused in IDLE while a command is pending so commands win.
  assign w_in_ready  = (r_state == ST_ACCUM) ||
                       ((r_state == ST_IDLE) && !cmd_clear && !cmd_final);
  assign w_in_hs     = in_valid && w_in_ready;
  // The label is taken live on element 0 and from the latch afterwards.
  assign w_cur_label = (r_state == ST_IDLE) ? in_label : r_label;
  assign w_ham_add   = w_in_hs && (w_cur_label == LABEL_HAM);
  assign w_spam_add  = w_in_hs && (w_cur_label == LABEL_SPAM);
  assign w_clr       = (r_state == ST_CLEAR);
  assign w_idx_last  = (r_idx == LAST_IDX);

  // The read port looks one beat ahead: index 0 when launching the sweep,
  // the following index while a beat is being presented.
  assign w_out_idx_nxt = r_out_idx + IDX_W'(1);
  assign w_rd_idx      = (r_state == ST_FINAL) ? w_out_idx_nxt : '0;

  hdc_acc_bank #(.DIM(DIM), .ACC_W(ACC_W), .IDX_W(IDX_W)) u_ham_bank (
    .clk       (clk),
    .i_clr     (w_clr),
    .i_add     (w_ham_add),
    .i_wr_idx  (r_idx),
    .i_elem    (in_elem),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_ham_rd)
  );

  hdc_acc_bank #(.DIM(DIM), .ACC_W(ACC_W), .IDX_W(IDX_W)) u_spam_bank (
    .clk       (clk),
    .i_clr     (w_clr),
    .i_add     (w_spam_add),
    .i_wr_idx  (r_idx),
    .i_elem    (in_elem),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_spam_rd)
  );

  // Controller: command decode, sample indexing, clear sweep and output sweep.
  // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_CLEAR;
      r_idx       <= '0;
      r_label     <= LABEL_SPAM;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_ham   <= ELEM_ZERO;
      r_out_spam  <= ELEM_ZERO;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_clear) begin
            r_state <= ST_CLEAR;
          end else if (cmd_final) begin
            r_state     <= ST_FINAL;
            r_out_valid <= 1'b1;
            r_out_idx   <= '0;
            r_out_ham   <= binarize(w_ham_rd);
            r_out_spam  <= binarize(w_spam_rd);
            r_out_last  <= (LAST_IDX == '0);
          end else if (w_in_hs) begin
            r_label <= in_label;
            r_idx   <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            r_state <= w_idx_last ? ST_IDLE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_in_hs) begin
            r_idx   <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            r_state <= w_idx_last ? ST_IDLE : ST_ACCUM;
          end
        end
        ST_CLEAR: begin
          r_idx   <= w_idx_last ? '0 : r_idx + IDX_W'(1);
          r_state <= w_idx_last ? ST_IDLE : ST_CLEAR;
        end
        ST_FINAL: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_state     <= ST_IDLE;
              r_out_valid <= 1'b0;
              r_out_idx   <= '0;
              r_out_ham   <= ELEM_ZERO;
              r_out_spam  <= ELEM_ZERO;
              r_out_last  <= 1'b0;
            end else begin
              r_out_idx  <= w_out_idx_nxt;
              r_out_ham  <= binarize(w_ham_rd);
              r_out_spam <= binarize(w_spam_rd);
              r_out_last <= (w_out_idx_nxt == LAST_IDX);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Per-class sample counters: bumped on a sample's final element,
  // saturating at all-ones, zeroed at the end of a clear sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ham_count  <= '0;
      r_spam_count <= '0;
    end else if (w_clr && w_idx_last) begin
      r_ham_count  <= '0;
      r_spam_count <= '0;
    end else if (w_in_hs && w_idx_last) begin
      if (w_cur_label == LABEL_HAM) begin
        if (r_ham_count != '1) r_ham_count <= r_ham_count + CNT_W'(1);
      end else begin
        if (r_spam_count != '1) r_spam_count <= r_spam_count + CNT_W'(1);
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_idx    = r_out_idx;
  assign out_ham    = r_out_ham;
  assign out_spam   = r_out_spam;
  assign out_last   = r_out_last;
  assign busy       = (r_state != ST_IDLE);
  assign ham_count  = r_ham_count;
  assign spam_count = r_spam_count;

endmodule

// File: tb/tb_hdc_class_trainer.sv
// tb_hdc_class_trainer: self-checking bench for hdc_class_trainer
// (DIM=8, ACC_W=4, CNT_W=4). The reference model keeps plain integer
// accumulators and counters per class. HDC_TRAIN_SAT_EN selects the
// saturating model to match the build.
module tb_hdc_class_trainer;

  localparam int DIM   = 8;
  localparam int ACC_W = 4;
  localparam int CNT_W = 4;
  localparam int IDX_W = $clog2(DIM);
  localparam int ACC_HI  = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_LO  = -(1 << (ACC_W - 1));
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_clear = 1'b0;
  logic             cmd_final = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_elem = 2'b00;
  logic             in_label = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [IDX_W-1:0] out_idx;
  logic [1:0]       out_ham;
  logic [1:0]       out_spam;
  logic             out_last;
  logic             busy;
  logic [CNT_W-1:0] ham_count;
  logic [CNT_W-1:0] spam_count;

  hdc_class_trainer #(.DIM(DIM), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_clear  (cmd_clear),
    .cmd_final  (cmd_final),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_elem    (in_elem),
    .in_label   (in_label),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_ham    (out_ham),
    .out_spam   (out_spam),
    .out_last   (out_last),
    .busy       (busy),
    .ham_count  (ham_count),
    .spam_count (spam_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int m_ham  [DIM];
  int m_spam [DIM];
  int m_ham_cnt;
  int m_spam_cnt;

  typedef struct packed {
    logic clr;
    logic fin;
    logic exp_ready;
  } cmd_vec_t;

  typedef struct packed {
    logic                 label;
    logic [DIM-1:0][1:0]  elems;
  } sample_vec_t;

  cmd_vec_t    cmd_tab [4];
  sample_vec_t sample_tab [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int elem_int(input logic [1:0] e);
    if (e == 2'b01) return 1;
    if (e == 2'b11) return -1;
    return 0;
  endfunction

  function automatic logic [1:0] enc(input int v);
    if (v > 0) return 2'b01;
    if (v < 0) return 2'b11;
    return 2'b00;
  endfunction

  function automatic int acc_add(input int a, input int d);
    int s;
    s = a + d;
`ifdef HDC_TRAIN_SAT_EN
    if (s > ACC_HI) s = ACC_HI;
    if (s < ACC_LO) s = ACC_LO;
`else
    while (s > ACC_HI) s -= (1 << ACC_W);
    while (s < ACC_LO) s += (1 << ACC_W);
`endif
    return s;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DIM; i++) begin
      m_ham[i]  = 0;
      m_spam[i] = 0;
    end
    m_ham_cnt  = 0;
    m_spam_cnt = 0;
  endfunction

  // Count rising edges until busy drops; a clear sweep takes DIM of them.
  task automatic wait_clear(input string name);
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n), 32'(DIM));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_in_ready",   32'(in_ready),   32'(0));
    check("rst_out_valid",  32'(out_valid),  32'(0));
    check("rst_out_idx",    32'(out_idx),    32'(0));
    check("rst_out_ham",    32'(out_ham),    32'(0));
    check("rst_out_spam",   32'(out_spam),   32'(0));
    check("rst_out_last",   32'(out_last),   32'(0));
    check("rst_ham_count",  32'(ham_count),  32'(0));
    check("rst_spam_count", 32'(spam_count), 32'(0));
    reset = 1'b0;
    wait_clear("rst_clear_cycles");
  endtask

  task automatic pulse_clear();
    cmd_clear = 1'b1;
    @(negedge clk);
    cmd_clear = 1'b0;
    model_clear();
    wait_clear("cmd_clear_cycles");
  endtask

  // Stream elements first..last of a sample; later beats carry a random
  // label that must be ignored.
  task automatic send_range(input logic label, input logic [DIM-1:0][1:0] elems,
                            input int first, input int last);
    for (int k = first; k <= last; k++) begin
      int n = 0;
      in_valid = 1'b1;
      in_elem  = elems[k];
      in_label = (k == 0) ? label : 1'($urandom_range(0, 1));
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("in_ready_timeout", 32'(0), 32'(1));
      @(negedge clk);
      if (label) m_ham[k]  = acc_add(m_ham[k],  elem_int(elems[k]));
      else       m_spam[k] = acc_add(m_spam[k], elem_int(elems[k]));
    end
    in_valid = 1'b0;
    if (last == DIM - 1) begin
      if (label) begin
        if (m_ham_cnt < CNT_MAX) m_ham_cnt++;
      end else begin
        if (m_spam_cnt < CNT_MAX) m_spam_cnt++;
      end
    end
  endtask

  task automatic check_beat(input string tag, input int k);
    check({tag, "_idx"},  32'(out_idx),  32'(k));
    check({tag, "_ham"},  32'(out_ham),  32'(enc(m_ham[k])));
    check({tag, "_spam"}, 32'(out_spam), 32'(enc(m_spam[k])));
    check({tag, "_last"}, 32'(out_last), 32'(k == DIM - 1));
  endtask

  // Run the output sweep, optionally stalling the consumer on one beat.
  task automatic run_final(input int stall_idx, input int stall_n);
    cmd_final = 1'b1;
    @(negedge clk);
    cmd_final = 1'b0;
    check("final_valid_rise", 32'(out_valid), 32'(1));
    for (int k = 0; k < DIM; k++) begin
      int n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("beat%0d_valid", k), 32'(out_valid), 32'(1));
      check_beat($sformatf("beat%0d", k), k);
      if (k == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          check($sformatf("stall%0d_valid", s), 32'(out_valid), 32'(1));
          check_beat($sformatf("stall%0d", s), k);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    check("final_done_valid", 32'(out_valid), 32'(0));
    check("final_done_busy",  32'(busy),      32'(0));
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ham_count"},  32'(ham_count),  32'(m_ham_cnt));
    check({tag, "_spam_count"}, 32'(spam_count), 32'(m_spam_cnt));
  endtask

  initial begin
    int pat_ham [DIM] = '{1, 1, -1, 0, 1, -1, -1, 1};
    logic [DIM-1:0][1:0] v;

    cmd_tab[0] = '{clr: 1'b0, fin: 1'b0, exp_ready: 1'b1};
    cmd_tab[1] = '{clr: 1'b1, fin: 1'b0, exp_ready: 1'b0};
    cmd_tab[2] = '{clr: 1'b0, fin: 1'b1, exp_ready: 1'b0};
    cmd_tab[3] = '{clr: 1'b1, fin: 1'b1, exp_ready: 1'b0};

    sample_tab[0].label = 1'b1;
    sample_tab[1].label = 1'b0;
    for (int k = 0; k < DIM; k++) begin
      sample_tab[0].elems[k] = enc(pat_ham[k]);
      sample_tab[1].elems[k] = 2'b11;
    end

    // Reset, automatic clear sweep.
    apply_reset();
    check("idle_busy", 32'(busy), 32'(0));

    // in_ready against command inputs in IDLE (combinational, no edge taken).
    for (int i = 0; i < 4; i++) begin
      cmd_clear = cmd_tab[i].clr;
      cmd_final = cmd_tab[i].fin;
      #1;
      check($sformatf("cmd_ready%0d", i), 32'(in_ready), 32'(cmd_tab[i].exp_ready));
      cmd_clear = 1'b0;
      cmd_final = 1'b0;
      @(negedge clk);
    end

    // Empty accumulators binarize to zero.
    run_final(-1, 0);

    // Fixed ham and spam samples.
    for (int i = 0; i < 2; i++) begin
      send_range(sample_tab[i].label, sample_tab[i].elems, 0, DIM - 1);
    end
    check_counts("fixed");
    run_final(-1, 0);

    // Both commands together: clear wins, no output sweep.
    cmd_clear = 1'b1;
    cmd_final = 1'b1;
    @(negedge clk);
    cmd_clear = 1'b0;
    cmd_final = 1'b0;
    check("both_cmd_no_valid", 32'(out_valid), 32'(0));
    model_clear();
    wait_clear("both_cmd_clear_cycles");
    check_counts("both_cmd");
    check("both_cmd_no_valid_after", 32'(out_valid), 32'(0));

    // cmd_final mid-sample is ignored.
    for (int k = 0; k < DIM; k++) v[k] = 2'($urandom_range(0, 3));
    send_range(1'b0, v, 0, 3);
    cmd_final = 1'b1;
    @(negedge clk);
    cmd_final = 1'b0;
    check("accum_final_valid", 32'(out_valid), 32'(0));
    check("accum_final_busy",  32'(busy),      32'(1));
    check("accum_final_ready", 32'(in_ready),  32'(1));
    send_range(1'b0, v, 4, DIM - 1);
    check_counts("accum_final");

    // Random samples, then a sweep with a 3-cycle stall on beat 2.
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < DIM; k++) v[k] = 2'($urandom_range(0, 3));
      send_range(1'($urandom_range(0, 1)), v, 0, DIM - 1);
    end
    check_counts("random");
    run_final(2, 3);

    // Reset at element 5 discards the partial sample.
    for (int k = 0; k < DIM; k++) v[k] = 2'($urandom_range(0, 3));
    send_range(1'b1, v, 0, 4);
    in_valid = 1'b1;
    in_elem  = v[5];
    #2;
    apply_reset();
    check_counts("midreset");
    send_range(1'b1, v, 0, DIM - 1);
    check_counts("after_midreset");
    run_final(-1, 0);

    // 16 all-(+1) ham samples: saturate or wrap depending on build;
    // the ham counter saturates at all-ones.
    pulse_clear();
    for (int k = 0; k < DIM; k++) v[k] = 2'b01;
    for (int s = 0; s < 16; s++) send_range(1'b1, v, 0, DIM - 1);
    check_counts("sat16");
    run_final(-1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
